// File: rtl/dct4x4_core.sv
// 4x4 integer forward transform Y = C*X*C^T: four row passes, four column passes, four output beats.
// Define DCT_BLOCK_COUNT_EN to add the block_count output (completed-block counter).
module dct4x4_core (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] residual_flat,
   input  logic [1:0]   mode,
   input  logic         residual_ready,
   output logic         DCT_busy,
   output logic [63:0]  coeff_flat,
   output logic [1:0]   coeff_row,
   output logic [1:0]   coeff_mode,
   output logic         coeff_valid,
   input  logic         coeff_ready,
   output logic         coeff_last
`ifdef DCT_BLOCK_COUNT_EN
   ,
   output logic [15:0]  block_count
`endif
);

   typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;
   typedef logic [3:0][15:0] vec4_t;

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] x_q, x_d;
   logic [255:0] t_q, t_d;
   logic [255:0] y_q, y_d;
   logic [1:0]   mode_q, mode_d;
   logic [1:0]   row_q, row_d;
   logic         valid_q, valid_d;
   logic         last_q, last_d;
`ifdef DCT_BLOCK_COUNT_EN
   logic [15:0]  bc_q, bc_d;
`endif

   int    cnt_i;
   vec4_t row_res;
   vec4_t col_res;

   // Butterfly form of one 1-D pass; 16-bit signed is ample for both passes.
   function automatic vec4_t dct1d(input logic signed [15:0] a0,
                                   input logic signed [15:0] a1,
                                   input logic signed [15:0] a2,
                                   input logic signed [15:0] a3);
      logic signed [15:0] s03, d03, s12, d12;
      vec4_t v;
      s03  = a0 + a3;
      d03  = a0 - a3;
      s12  = a1 + a2;
      d12  = a1 - a2;
      v[0] = s03 + s12;
      v[1] = (d03 <<< 1) + d12;
      v[2] = s03 - s12;
      v[3] = d03 - (d12 <<< 1);
      return v;
   endfunction

   function automatic logic signed [15:0] sx8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   assign cnt_i = int'(cnt_q);

   always_comb begin
      row_res = dct1d(sx8(x_q[8*(4*cnt_i+0) +: 8]),
                      sx8(x_q[8*(4*cnt_i+1) +: 8]),
                      sx8(x_q[8*(4*cnt_i+2) +: 8]),
                      sx8(x_q[8*(4*cnt_i+3) +: 8]));
      col_res = dct1d(t_q[16*(0+cnt_i) +: 16],
                      t_q[16*(4+cnt_i) +: 16],
                      t_q[16*(8+cnt_i) +: 16],
                      t_q[16*(12+cnt_i) +: 16]);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      t_d     = t_q;
      y_d     = y_q;
      mode_d  = mode_q;
      row_d   = row_q;
      valid_d = valid_q;
      last_d  = last_q;
`ifdef DCT_BLOCK_COUNT_EN
      bc_d    = bc_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (residual_ready) begin
               x_d     = residual_flat;
               mode_d  = mode;
               cnt_d   = 2'd0;
               state_d = ROW;
            end
         end
         ROW: begin
            for (int j = 0; j < 4; j++)
               t_d[16*(4*cnt_i+j) +: 16] = row_res[j];
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = COL;
         end
         COL: begin
            for (int i = 0; i < 4; i++)
               y_d[16*(4*i+cnt_i) +: 16] = col_res[i];
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = OUT;
               valid_d = 1'b1;
               row_d   = 2'd0;
               last_d  = 1'b0;
            end
         end
         OUT: begin
            if (coeff_ready) begin
               if (row_q == 2'd3) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  row_d   = 2'd0;
`ifdef DCT_BLOCK_COUNT_EN
                  bc_d    = bc_q + 16'd1;
`endif
               end else begin
                  row_d  = row_q + 2'd1;
                  last_d = (row_q == 2'd2);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         t_q     <= '0;
         y_q     <= '0;
         mode_q  <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
`ifdef DCT_BLOCK_COUNT_EN
         bc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         t_q     <= t_d;
         y_q     <= y_d;
         mode_q  <= mode_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         last_q  <= last_d;
`ifdef DCT_BLOCK_COUNT_EN
         bc_q    <= bc_d;
`endif
      end
   end

   assign DCT_busy    = (state_q != IDLE);
   assign coeff_flat  = y_q[64*int'(row_q) +: 64];
   assign coeff_row   = row_q;
   assign coeff_mode  = mode_q;
   assign coeff_valid = valid_q;
   assign coeff_last  = last_q;
`ifdef DCT_BLOCK_COUNT_EN
   assign block_count = bc_q;
`endif

endmodule

// File: tb/tb_dct4x4_core.sv
// Directed bench for dct4x4_core: hand-computed coefficient blocks, latency, stall, reset.
module tb_dct4x4_core;

   logic         clk;
   logic         rst;
   logic [127:0] residual_flat;
   logic [1:0]   mode;
   logic         residual_ready;
   logic         DCT_busy;
   logic [63:0]  coeff_flat;
   logic [1:0]   coeff_row;
   logic [1:0]   coeff_mode;
   logic         coeff_valid;
   logic         coeff_ready;
   logic         coeff_last;
`ifdef DCT_BLOCK_COUNT_EN
   logic [15:0]  block_count;
`endif

   int compared = 0;
   int mismatched = 0;

   dct4x4_core dut (
      .clk            (clk),
      .rst            (rst),
      .residual_flat  (residual_flat),
      .mode           (mode),
      .residual_ready (residual_ready),
      .DCT_busy       (DCT_busy),
      .coeff_flat     (coeff_flat),
      .coeff_row      (coeff_row),
      .coeff_mode     (coeff_mode),
      .coeff_valid    (coeff_valid),
      .coeff_ready    (coeff_ready),
      .coeff_last     (coeff_last)
`ifdef DCT_BLOCK_COUNT_EN
      ,
      .block_count    (block_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] row4(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic logic [255:0] blk4(input logic [63:0] r0, input logic [63:0] r1,
                                         input logic [63:0] r2, input logic [63:0] r3);
      return {r3, r2, r1, r0};
   endfunction

   // Called at a falling edge; the block is accepted on the next rising edge.
   task automatic do_block(input string tag, input logic [127:0] blk, input logic [1:0] md,
                           input logic [255:0] exp, input int stall);
      int n;
      residual_flat  = blk;
      mode           = md;
      residual_ready = 1'b1;
      @(negedge clk);
      residual_ready = 1'b0;
      residual_flat  = ~blk;
      mode           = ~md;
      chk({tag, "_busy"}, 64'(DCT_busy), 64'd1);
      n = 0;
      while (!coeff_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd8);
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s_row%0d", tag, r), 64'(coeff_row), 64'(r));
         chk($sformatf("%s_flat%0d", tag, r), coeff_flat, exp[64*r +: 64]);
         chk($sformatf("%s_last%0d", tag, r), 64'(coeff_last), 64'(r == 3));
         chk($sformatf("%s_mode%0d", tag, r), 64'(coeff_mode), 64'(md));
         chk($sformatf("%s_valid%0d", tag, r), 64'(coeff_valid), 64'd1);
         if (r == stall) begin
            coeff_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               residual_ready = 1'b1;
               @(negedge clk);
               chk($sformatf("%s_hold_row%0d", tag, s), 64'(coeff_row), 64'(r));
               chk($sformatf("%s_hold_flat%0d", tag, s), coeff_flat, exp[64*r +: 64]);
               chk($sformatf("%s_hold_last%0d", tag, s), 64'(coeff_last), 64'(r == 3));
               chk($sformatf("%s_hold_mode%0d", tag, s), 64'(coeff_mode), 64'(md));
               chk($sformatf("%s_hold_valid%0d", tag, s), 64'(coeff_valid), 64'd1);
            end
            residual_ready = 1'b0;
            coeff_ready    = 1'b1;
         end
         @(negedge clk);
      end
      chk({tag, "_done_valid"}, 64'(coeff_valid), 64'd0);
      chk({tag, "_done_busy"}, 64'(DCT_busy), 64'd0);
   endtask

   initial begin
      logic [127:0] b;
      logic [255:0] e;
      logic [63:0]  z;

      rst            = 1'b1;
      residual_flat  = '0;
      mode           = 2'd0;
      residual_ready = 1'b0;
      coeff_ready    = 1'b1;
      z              = '0;
      repeat (3) @(negedge clk);

      chk("rst_busy", 64'(DCT_busy), 64'd0);
      chk("rst_valid", 64'(coeff_valid), 64'd0);
      chk("rst_last", 64'(coeff_last), 64'd0);
      chk("rst_row", 64'(coeff_row), 64'd0);
      chk("rst_mode", 64'(coeff_mode), 64'd0);
      chk("rst_flat", coeff_flat, 64'd0);
`ifdef DCT_BLOCK_COUNT_EN
      chk("rst_count", 64'(block_count), 64'd0);
`endif

      // Accepted on the first edge after reset release.
      rst = 1'b0;
      do_block("zero", '0, 2'd2, {z, z, z, z}, -1);

      b = {16{8'd1}};
      e = blk4(row4(16, 0, 0, 0), z, z, z);
      do_block("ones", b, 2'd1, e, -1);

      b = {16{8'h80}};
      e = blk4(row4(-2048, 0, 0, 0), z, z, z);
      do_block("neg128", b, 2'd3, e, -1);

      b = '0;
      b[7:0] = 8'd1;
      e = blk4(row4(1, 2, 1, 1), row4(2, 4, 2, 2), row4(1, 2, 1, 1), row4(1, 2, 1, 1));
      do_block("imp00", b, 2'd0, e, -1);

      b = '0;
      b[39:32] = 8'd1;
      e = blk4(row4(1, 2, 1, 1), row4(1, 2, 1, 1),
               row4(-1, -2, -1, -1), row4(-2, -4, -2, -2));
      do_block("stall10", b, 2'd2, e, 1);

      // Reset while the column pass is running.
      b = '0;
      b[7:0] = 8'd1;
      residual_flat  = b;
      mode           = 2'd3;
      residual_ready = 1'b1;
      @(negedge clk);
      residual_ready = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_busy", 64'(DCT_busy), 64'd0);
      chk("mid_valid", 64'(coeff_valid), 64'd0);
      chk("mid_last", 64'(coeff_last), 64'd0);
      chk("mid_row", 64'(coeff_row), 64'd0);
      chk("mid_mode", 64'(coeff_mode), 64'd0);
      chk("mid_flat", coeff_flat, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      b = '0;
      b[15:8] = 8'd1;
      e = blk4(row4(1, 1, -1, -2), row4(2, 2, -2, -4),
               row4(1, 1, -1, -2), row4(1, 1, -1, -2));
      do_block("imp01", b, 2'd1, e, -1);

      // Back-to-back: next block offered in the IDLE cycle right after return.
      b = {16{8'd1}};
      e = blk4(row4(16, 0, 0, 0), z, z, z);
      do_block("b2b_ones", b, 2'd2, e, -1);

      b = '0;
      b[7:0] = 8'd1;
      e = blk4(row4(1, 2, 1, 1), row4(2, 4, 2, 2), row4(1, 2, 1, 1), row4(1, 2, 1, 1));
      do_block("b2b_imp", b, 2'd3, e, -1);

`ifdef DCT_BLOCK_COUNT_EN
      chk("count3", 64'(block_count), 64'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
